// File: rtl/dff_bank_pkg.sv
// ---------------------------------------------------------------------------
// dff_bank_pkg
// Shared types and constants for the async-control DFF bank sequencer and
// the checkers that reuse its comparator.
//   op_e    : 2-bit command opcode (LOAD/CLEAR/PRESET/CHECK)
//   state_e : sequencer FSM states, fixed legacy encodings
//   DEF_*   : default membership patterns for an 8-bit bank
// ---------------------------------------------------------------------------
package dff_bank_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_PRESET = 2'd2,
        OP_CHECK  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam int unsigned DEF_W = 8;
    localparam logic [DEF_W-1:0] DEF_PAT_A = '0;
    localparam logic [DEF_W-1:0] DEF_PAT_B = '1;

    // Settle counter width; covers SETTLE_CYC in 0..15.
    localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/dff_bank_cmp.sv
// ---------------------------------------------------------------------------
// dff_bank_cmp
// Combinational read-side checker for a DFF bank.
//   q_i        : sampled bank outputs
//   exp_i      : value the bank is expected to hold
//   mismatch_o : q_i differs from exp_i
//   match_o    : q_i equals PAT_A or PAT_B
// ---------------------------------------------------------------------------
module dff_bank_cmp
    import dff_bank_pkg::*;
#(
    parameter int unsigned    W     = DEF_W,
    parameter logic [W-1:0]   PAT_A = '0,
    parameter logic [W-1:0]   PAT_B = '1
) (
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] exp_i,
    output logic         mismatch_o,
    output logic         match_o
);

    assign mismatch_o = (q_i != exp_i);

    // Identical patterns collapse to one comparator.
    if (PAT_A == PAT_B) begin : g_single
        assign match_o = (q_i == PAT_A);
    end else begin : g_pair
        assign match_o = (q_i == PAT_A) || (q_i == PAT_B);
    end

endmodule

// File: rtl/dff_bank_sequencer.sv
// ---------------------------------------------------------------------------
// dff_bank_sequencer
// Writer-plus-checker for the async-control DFF bank. Takes one command at a
// time, pulses the bank's load/clear/preset control for one cycle, waits
// SETTLE_CYC cycles for clk->q, samples bank_q and returns a response with an
// expected-value check and a pattern-membership flag.
//   clk, clr             : clock, synchronous active-high reset
//   cmd_valid/ready      : command handshake; cmd_op, cmd_data payload
//   bank_di/ce/clr/pr    : registered bank controls
//   bank_q               : bank outputs
//   rsp_valid/ready      : response handshake; rsp_q, rsp_err, rsp_match
//   err_cnt              : saturating count of responses with rsp_err=1
// ---------------------------------------------------------------------------
module dff_bank_sequencer
    import dff_bank_pkg::*;
#(
    parameter int unsigned  W          = 8,
    parameter int unsigned  SETTLE_CYC = 2,
    parameter logic [W-1:0] PAT_A      = {W{1'b0}},
    parameter logic [W-1:0] PAT_B      = {W{1'b1}},
    parameter int unsigned  ERRW       = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [W-1:0]    cmd_data,
    output logic [W-1:0]    bank_di,
    output logic            bank_ce,
    output logic            bank_clr,
    output logic            bank_pr,
    input  logic [W-1:0]    bank_q,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_q,
    output logic            rsp_err,
    output logic            rsp_match,
    output logic [ERRW-1:0] err_cnt
);

    localparam bit                  HAS_SETTLE  = (SETTLE_CYC != 0);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = HAS_SETTLE ? SETTLE_W'(SETTLE_CYC - 1) : '0;
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [ERRW-1:0]     ERR_ONE     = ERRW'(1);

    state_e               state_q,     state_d;
    logic [SETTLE_W-1:0]  cnt_q,       cnt_d;
    logic [W-1:0]         exp_q,       exp_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic [W-1:0]         bank_di_q,   bank_di_d;
    logic                 bank_ce_q,   bank_ce_d;
    logic                 bank_clr_q,  bank_clr_d;
    logic                 bank_pr_q,   bank_pr_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [W-1:0]         rsp_data_q,  rsp_data_d;
    logic                 rsp_err_q,   rsp_err_d;
    logic                 rsp_match_q, rsp_match_d;
    logic [ERRW-1:0]      err_cnt_q,   err_cnt_d;

    op_e  cmd_op_e;
    logic mismatch;
    logic pat_match;

    assign cmd_op_e = op_e'(cmd_op);

    dff_bank_cmp #(
        .W     (W),
        .PAT_A (PAT_A),
        .PAT_B (PAT_B)
    ) u_cmp (
        .q_i        (bank_q),
        .exp_i      (exp_q),
        .mismatch_o (mismatch),
        .match_o    (pat_match)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        bank_di_d   = bank_di_q;
        bank_ce_d   = 1'b0;
        bank_clr_d  = 1'b0;
        bank_pr_d   = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_match_d = rsp_match_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Controls are registered, so the pulse for the accepted op
                // is set up here and is visible during the DRIVE cycle.
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ST_DRIVE;
                    case (cmd_op_e)
                        OP_LOAD: begin
                            bank_di_d = cmd_data;
                            bank_ce_d = 1'b1;
                            exp_d     = cmd_data;
                        end
                        OP_CLEAR: begin
                            bank_clr_d = 1'b1;
                            exp_d      = '0;
                        end
                        OP_PRESET: begin
                            bank_pr_d = 1'b1;
                            exp_d     = '1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DRIVE: begin
                if (HAS_SETTLE) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - SETTLE_ONE;
                end
            end
            ST_SAMPLE: begin
                rsp_data_d  = bank_q;
                rsp_err_d   = mismatch;
                rsp_match_d = pat_match;
                rsp_valid_d = 1'b1;
                if (mismatch && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            exp_q       <= '0;
            cmd_ready_q <= 1'b0;
            bank_di_q   <= '0;
            bank_ce_q   <= 1'b0;
            // Clear the bank together with the sequencer.
            bank_clr_q  <= 1'b1;
            bank_pr_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_match_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            cmd_ready_q <= cmd_ready_d;
            bank_di_q   <= bank_di_d;
            bank_ce_q   <= bank_ce_d;
            bank_clr_q  <= bank_clr_d;
            bank_pr_q   <= bank_pr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_match_q <= rsp_match_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign bank_di   = bank_di_q;
    assign bank_ce   = bank_ce_q;
    assign bank_clr  = bank_clr_q;
    assign bank_pr   = bank_pr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_match = rsp_match_q;
    assign err_cnt   = err_cnt_q;

endmodule
